// File: rtl/l1_frame_acc16.sv
// Streaming L1 magnitude accumulator with per-frame peak/index; result registered on the
// edge the last sample is taken (1-edge latency); one-deep output buffer, only a frame's final sample stalls.
module l1_frame_acc16 #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 26,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [15:0]      out_peak,
    output logic [IDX_W-1:0] out_peak_idx
);

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      pk_q, pk_d;
    logic [IDX_W-1:0] pki_q, pki_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [15:0]      opk_q, opk_d;
    logic [IDX_W-1:0] opki_q, opki_d;

    logic [15:0] mag;
    logic        first_smp;
    logic        last_smp;
    logic        accept;
    logic        complete;

    // 0x8000 negates to itself, which read unsigned is exactly 32768
    assign mag       = in_data[15] ? (~in_data + 16'd1) : in_data;
    assign first_smp = (cnt_q == '0);
    assign last_smp  = (cnt_q == LAST_IDX);

    assign out_valid = (state_q == FULL);
    assign in_ready  = !rst && (!last_smp || !out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && last_smp;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        pk_d  = pk_q;
        pki_d = pki_q;
        if (accept) begin
            cnt_d = last_smp ? '0 : cnt_q + IDX_W'(1);
            if (first_smp) begin
                acc_d = ACC_W'(mag);
                pk_d  = mag;
                pki_d = '0;
            end else begin
                acc_d = acc_q + ACC_W'(mag);
                // strict compare keeps the earliest index on ties
                if (mag > pk_q) begin
                    pk_d  = mag;
                    pki_d = cnt_q;
                end
            end
        end
    end

    always_comb begin
        sum_d  = sum_q;
        opk_d  = opk_q;
        opki_d = opki_q;
        if (complete) begin
            sum_d  = acc_d;
            opk_d  = pk_d;
            opki_d = pki_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (complete) state_d = FULL;
            FULL:  if (out_ready && !complete) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            pk_q   <= '0;
            pki_q  <= '0;
            sum_q  <= '0;
            opk_q  <= '0;
            opki_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            pk_q   <= pk_d;
            pki_q  <= pki_d;
            sum_q  <= sum_d;
            opk_q  <= opk_d;
            opki_q <= opki_d;
        end
    end

    assign out_sum      = sum_q;
    assign out_peak     = opk_q;
    assign out_peak_idx = opki_q;

endmodule

// File: tb/tb_l1_frame_acc16.sv
// Bench for l1_frame_acc16 at FRAME_LEN=4: directed scenarios plus a scoreboard fed by a
// reference model on every accepted sample and drained on every output handshake.
module tb_l1_frame_acc16;
    localparam int FL = 4;
    localparam int AW = 26;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [15:0]   out_peak;
    logic [IW-1:0] out_peak_idx;

    l1_frame_acc16 #(.FRAME_LEN(FL), .ACC_W(AW), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_peak     (out_peak),
        .out_peak_idx (out_peak_idx)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int results = 0;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [15:0]   pk;
        logic [IW-1:0] idx;
    } res_t;

    res_t          sb[$];
    int            mcnt = 0;
    logic [AW-1:0] macc;
    logic [15:0]   mpk;
    logic [IW-1:0] mpki;

    function automatic logic [15:0] magf(input logic [15:0] d);
        return d[15] ? (16'd0 - d) : d;
    endfunction

    // Reference model and scoreboard; sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin : monitor
        res_t        e;
        logic [15:0] m;
        if (rst) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                results++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got sum=%0d peak=%h idx=%0d, expected no result",
                             out_sum, out_peak, out_peak_idx);
                end else begin
                    e = sb.pop_front();
                    if ({out_sum, out_peak, out_peak_idx} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got sum=%0d peak=%h idx=%0d, expected sum=%0d peak=%h idx=%0d",
                                 out_sum, out_peak, out_peak_idx, e.sum, e.pk, e.idx);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = magf(in_data);
                if (mcnt == 0) begin
                    macc = AW'(m);
                    mpk  = m;
                    mpki = '0;
                end else begin
                    macc = macc + AW'(m);
                    if (m > mpk) begin
                        mpk  = m;
                        mpki = IW'(mcnt);
                    end
                end
                if (mcnt == FL - 1) begin
                    sb.push_back('{sum: macc, pk: mpk, idx: mpki});
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Present one sample, hold until accepted; leaves in_valid high, returns at posedge+1.
    task automatic send(input logic [15:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%0d peak=%h idx=%0d expected all 0",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        @(posedge clk);
        #1;
        send(16'd3); send(16'hFFFB); send(16'd2); send(16'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd11, 16'd5, 10'd1}) begin
            errors++;
            $display("FAIL basic_result: got v=%b sum=%0d peak=%0d idx=%0d expected v=1 sum=11 peak=5 idx=1",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: out_valid=%b expected 0 one cycle later", out_valid);
        end
    endtask

    task automatic test_most_negative();
        @(posedge clk);
        #1;
        repeat (4) send(16'h8000);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd131072, 16'h8000, 10'd0}) begin
            errors++;
            $display("FAIL most_neg_all: got v=%b sum=%0d peak=%h idx=%0d expected v=1 sum=131072 peak=8000 idx=0",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
        @(posedge clk);
        #1;
        send(16'h7FFF); send(16'h8000); send(16'h0000); send(16'h0000);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd65535, 16'h8000, 10'd1}) begin
            errors++;
            $display("FAIL most_neg_mix: got v=%b sum=%0d peak=%h idx=%0d expected v=1 sum=65535 peak=8000 idx=1",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
    endtask

    task automatic test_tie();
        @(posedge clk);
        #1;
        send(16'd7); send(16'hFFF9); send(16'd7); send(16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd21, 16'd7, 10'd0}) begin
            errors++;
            $display("FAIL tie_rule: got v=%b sum=%0d peak=%0d idx=%0d expected v=1 sum=21 peak=7 idx=0",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) send(16'd1);
        repeat (3) send(16'd2);
        in_data = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 26'd4}) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got in_ready=%b v=%b sum=%0d expected in_ready=0 v=1 sum=4",
                         i, in_ready, out_valid, out_sum);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd8, 16'd2, 10'd0}) begin
            errors++;
            $display("FAIL bp_reload: got v=%b sum=%0d peak=%0d idx=%0d expected v=1 sum=8 peak=2 idx=0",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) send(16'd9);
        send(16'd5);
        send(16'd6);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %b expected 0 during rst", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 1'b0, 26'd0, 16'd0, 10'd0}) begin
            errors++;
            $display("FAIL rstmid_cleared: got in_ready=%b v=%b sum=%0d peak=%0d idx=%0d expected 1,0,0,0,0",
                     in_ready, out_valid, out_sum, out_peak, out_peak_idx);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_peak, out_peak_idx} !== {1'b1, 26'd10, 16'd4, 10'd3}) begin
            errors++;
            $display("FAIL rstmid_restart: got v=%b sum=%0d peak=%0d idx=%0d expected v=1 sum=10 peak=4 idx=3",
                     out_valid, out_sum, out_peak, out_peak_idx);
        end
    endtask

    task automatic test_streaming();
        int r0;
        int bubbles;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        r0 = results;
        bubbles = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 5) ? 16'h8000 : 16'($urandom);
            @(negedge clk);
            if (!in_ready) bubbles++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bubbles !== 0) begin
            errors++;
            $display("FAIL stream_bubbles: got %0d stalled cycles expected 0", bubbles);
        end
        checks++;
        if (results - r0 !== 16) begin
            errors++;
            $display("FAIL stream_count: got %0d results expected 16", results - r0);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL stream_leftover: got %0d unconsumed expected 0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_most_negative();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
